// File: rtl/sevenseg_value_encoder.sv
// Converts a bus-written binary value into per-digit 7-segment patterns (hex or decimal),
// and generates the free-running scan_en tick for the downstream display multiplexer.
module sevenseg_value_encoder #(
  parameter int N        = 2,
  parameter int W        = 8,
  parameter int PRESCALE = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] wdata,
  input  logic         dec_mode,
  output logic         busy,
  output logic [6:0]   digit_values [0:N-1],
  output logic         scan_en
);

  localparam int CW   = $clog2(W + 1);
  localparam int PW   = $clog2(PRESCALE);
  localparam int HW   = (W > 4 * N) ? W : 4 * N;
  localparam int CMPW = (W > 64) ? W : 64;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned P10 = pow10(N);
  // Decimal overflow is only reachable when 10**N fits in the value range.
  localparam bit DEC_CAN_OVF = (W >= 64) ? 1'b1 : (P10 <= ((64'd1 << W) - 64'd1));

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    val_q, bin_q;
  logic            mode_q;
  logic [4*N-1:0]  bcd_q, bcd_adj;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   pre_q;
  logic [HW-1:0]   hex_ext;
  logic            hex_ovf, dec_ovf, ovf, nz;
  logic [3:0]      nib;
  logic [6:0]      seg_nx [0:N-1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (we) state_nx = dec_mode ? SHIFT : ENCODE;
      SHIFT:   if (cnt_q == CW'(1)) state_nx = ENCODE;
      ENCODE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Double-dabble correction step applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign hex_ext = HW'(val_q);
  assign hex_ovf = (W > 4 * N) && ((hex_ext >> (4 * N)) != '0);
  assign dec_ovf = DEC_CAN_OVF && (CMPW'(val_q) >= CMPW'(P10));
  assign ovf     = mode_q ? dec_ovf : hex_ovf;

  // Walk from the top digit down so nz tracks "this or any higher digit non-zero".
  always_comb begin
    nz  = 1'b0;
    nib = 4'h0;
    for (int i = 0; i < N; i++) seg_nx[i] = 7'h7F;
    for (int i = N - 1; i >= 0; i--) begin
      nib = mode_q ? bcd_q[4*i +: 4] : hex_ext[4*i +: 4];
      nz  = nz | (nib != 4'h0);
      if (ovf)                               seg_nx[i] = 7'h3F;
      else if (BLANK_LZ != 0 && !nz && i != 0) seg_nx[i] = 7'h7F;
      else                                   seg_nx[i] = seg7(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= '0;
      bin_q  <= '0;
      mode_q <= 1'b0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < N; i++) digit_values[i] <= 7'h7F;
    end else begin
      case (state)
        IDLE: if (we) begin
          val_q  <= wdata;
          bin_q  <= wdata;
          mode_q <= dec_mode;
          bcd_q  <= '0;
          cnt_q  <= CW'(W);
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[4*N-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q - CW'(1);
        end
        ENCODE: for (int i = 0; i < N; i++) digit_values[i] <= seg_nx[i];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                            pre_q <= '0;
    else if (pre_q == PW'(PRESCALE - 1))  pre_q <= '0;
    else                                  pre_q <= pre_q + PW'(1);
  end

  assign scan_en = (pre_q == PW'(PRESCALE - 1));

endmodule
